// File: rtl/fabulous_acc_pkg.sv
// Shared definitions for the segmented pipelined accumulator.
// Token layout and segment-count helper.
package fabulous_acc_pkg;

    localparam int TOK_VALID = 0;
    localparam int TOK_SUB   = 1;
    localparam int TOK_LOAD  = 2;
    localparam int TOK_W     = 3;

    function automatic int seg_count(input int width, input int seg_width);
        return width / seg_width;
    endfunction

endpackage

// File: rtl/fabulous_acc_seg.sv
// One carry segment: half-adder ripple chain, accumulator slice,
// registered carry-out and the token that travels with the slice.
module fabulous_acc_seg
    import fabulous_acc_pkg::*;
#(
    parameter int SEG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 sr,
    input  logic                 adv,
    input  logic [TOK_W-1:0]     tok_in,
    input  logic [SEG_WIDTH-1:0] a,
    input  logic                 cin,
    output logic [TOK_W-1:0]     tok,
    output logic [SEG_WIDTH-1:0] acc,
    output logic                 cout
);

    logic [SEG_WIDTH-1:0] b;
    logic [SEG_WIDTH-1:0] sum;
    logic                 carry;

    // Per-bit half-adder pair with propagate/generate, as in LUT4_HA
    always_comb begin
        b     = tok_in[TOK_SUB] ? ~a : a;
        sum   = '0;
        carry = cin;
        for (int i = 0; i < SEG_WIDTH; i++) begin
            sum[i] = acc[i] ^ b[i] ^ carry;
            carry  = (acc[i] & b[i]) | (carry & (acc[i] ^ b[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (sr) begin
            tok  <= '0;
            acc  <= '0;
            cout <= 1'b0;
        end else if (adv) begin
            tok <= tok_in;
            if (tok_in[TOK_VALID]) begin
                if (tok_in[TOK_LOAD]) begin
                    acc  <= a;
                    cout <= 1'b0;
                end else begin
                    acc  <= sum;
                    cout <= carry;
                end
            end
        end
    end

endmodule

// File: rtl/fabulous_ha_pipe_accum.sv
// Segmented pipelined accumulator: input skew, segment chain, output deskew.
// Optional sticky OVF flag built when FABULOUS_ACC_STICKY_OVF_EN is defined.
module fabulous_ha_pipe_accum
    import fabulous_acc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SEG_WIDTH = 4
) (
    input  logic             CLK,
    input  logic             SR,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic             SUB,
    input  logic             LOAD,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             OVF
);

    localparam int NSEG = seg_count(WIDTH, SEG_WIDTH);

    logic                 adv;
    logic [TOK_W-1:0]     tok     [NSEG+1];
    logic [SEG_WIDTH-1:0] slice_a [NSEG];
    logic [SEG_WIDTH-1:0] acc     [NSEG];
    logic                 cout    [NSEG];
    logic                 cin     [NSEG];

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = tok[NSEG][TOK_VALID];
    assign CO        = cout[NSEG-1];

    always_comb begin
        tok[0] = '0;
        if (in_valid) begin
            tok[0][TOK_VALID] = 1'b1;
            tok[0][TOK_SUB]   = SUB;
            tok[0][TOK_LOAD]  = LOAD;
        end
    end

    assign slice_a[0] = A[SEG_WIDTH-1:0];

    // Slice j waits j advances so it meets its operand's carry
    for (genvar j = 1; j < NSEG; j++) begin : g_skew
        logic [SEG_WIDTH-1:0] sk [j];
        always_ff @(posedge CLK) begin
            if (SR) begin
                for (int i = 0; i < j; i++) sk[i] <= '0;
            end else if (adv) begin
                sk[0] <= A[j*SEG_WIDTH +: SEG_WIDTH];
                for (int i = 1; i < j; i++) sk[i] <= sk[i-1];
            end
        end
        assign slice_a[j] = sk[j-1];
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        if (k == 0) begin : g_cin0
            assign cin[k] = tok[0][TOK_SUB];
        end else begin : g_cink
            assign cin[k] = cout[k-1];
        end

        fabulous_acc_seg #(
            .SEG_WIDTH(SEG_WIDTH)
        ) u_seg (
            .clk   (CLK),
            .sr    (SR),
            .adv   (adv),
            .tok_in(tok[k]),
            .a     (slice_a[k]),
            .cin   (cin[k]),
            .tok   (tok[k+1]),
            .acc   (acc[k]),
            .cout  (cout[k])
        );
    end

    // Lower slices finish early and wait here for the top slice
    for (genvar k = 0; k < NSEG - 1; k++) begin : g_deskew
        localparam int D = NSEG - 1 - k;
        logic [SEG_WIDTH-1:0] ds [D];
        always_ff @(posedge CLK) begin
            if (SR) begin
                for (int i = 0; i < D; i++) ds[i] <= '0;
            end else if (adv) begin
                ds[0] <= acc[k];
                for (int i = 1; i < D; i++) ds[i] <= ds[i-1];
            end
        end
        assign Y[k*SEG_WIDTH +: SEG_WIDTH] = ds[D-1];
    end

    assign Y[(NSEG-1)*SEG_WIDTH +: SEG_WIDTH] = acc[NSEG-1];

`ifdef FABULOUS_ACC_STICKY_OVF_EN
    logic ovf_q;
    always_ff @(posedge CLK) begin
        if (SR) begin
            ovf_q <= 1'b0;
        end else if (out_valid && out_ready) begin
            if (tok[NSEG][TOK_LOAD]) ovf_q <= 1'b0;
            else if (CO)             ovf_q <= 1'b1;
        end
    end
    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

    logic unused_tok;
    assign unused_tok = ^{tok[NSEG][TOK_SUB], tok[NSEG][TOK_LOAD]};

endmodule

// File: tb/tb_fabulous_ha_pipe_accum.sv
// Randomized and directed bench for fabulous_ha_pipe_accum
// against a sequential accumulator reference with an in-order result queue.
module tb_fabulous_ha_pipe_accum;

    localparam int W    = 16;
    localparam int NSEG = 4;

    logic         clk = 1'b0;
    logic         SR;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic         SUB;
    logic         LOAD;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Y;
    logic         CO;
    logic         OVF;

    always #5 clk = ~clk;

    fabulous_ha_pipe_accum #(
        .WIDTH(W),
        .SEG_WIDTH(4)
    ) dut (
        .CLK      (clk),
        .SR       (SR),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .SUB      (SUB),
        .LOAD     (LOAD),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y        (Y),
        .CO       (CO),
        .OVF      (OVF)
    );

    typedef struct {
        logic [W-1:0] y;
        logic         co;
        logic         load;
        int           age;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] ref_acc;
    logic         model_ovf;
    logic [W-1:0] last_y;
    logic         last_co;
    int           n_out;
    int           checks;
    int           errors;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Sequential reference: one operand applied to the whole-width accumulator
    function automatic exp_t model(input logic [W-1:0] a, input bit sub,
                                   input bit load);
        exp_t e;
        int   s;
        e.load = load;
        e.age  = 0;
        if (load) begin
            ref_acc = a;
            e.co    = 1'b0;
        end else if (sub) begin
            e.co    = (ref_acc >= a);
            ref_acc = ref_acc - a;
        end else begin
            s       = int'(ref_acc) + int'(a);
            e.co    = (s > 65535);
            ref_acc = ref_acc + a;
        end
        e.y = ref_acc;
        return e;
    endfunction

    task automatic cycle(input bit iv, input logic [W-1:0] a, input bit sub,
                         input bit load, input bit ordy, input bit sr);
        exp_t e;
        bit   ev;
        bit   adv_m;
        in_valid  = iv;
        A         = a;
        SUB       = sub;
        LOAD      = load;
        out_ready = ordy;
        SR        = sr;
        #1;
        ev    = (q.size() > 0) && (q[0].age >= NSEG - 1);
        adv_m = !ev || ordy;
        check("out_valid", out_valid, ev);
        check("in_ready", in_ready, adv_m);
        check("ovf", OVF, model_ovf);
        if (ev) begin
            check("y", Y, q[0].y);
            check("co", CO, q[0].co);
        end
        if (sr) begin
            q.delete();
            ref_acc   = '0;
            model_ovf = 1'b0;
        end else if (adv_m) begin
            if (ev && ordy) begin
                e       = q.pop_front();
                last_y  = Y;
                last_co = CO;
                n_out++;
`ifdef FABULOUS_ACC_STICKY_OVF_EN
                if (e.load)    model_ovf = 1'b0;
                else if (e.co) model_ovf = 1'b1;
`endif
            end
            foreach (q[i]) q[i].age++;
            if (iv) q.push_back(model(a, sub, load));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op(input logic [W-1:0] a, input bit sub, input bit load);
        cycle(1'b1, a, sub, load, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++)
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("drain", q.size(), 0);
    endtask

    initial begin
        int base;
        checks    = 0;
        errors    = 0;
        n_out     = 0;
        ref_acc   = '0;
        model_ovf = 1'b0;
        last_y    = '0;
        last_co   = 1'b0;
        SR        = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        SUB       = 1'b0;
        LOAD      = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rst_y", Y, 0);
        check("rst_co", CO, 0);
        check("rst_ovf", OVF, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_iready", in_ready, 1);

        op(16'h1234, 1'b0, 1'b1);
        op(16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lat_first_valid", out_valid, 1);
        check("lat_first_y", Y, 16'h1234);
        drain();
        check("add_y", last_y, 16'h1235);
        check("add_co", last_co, 0);

        op(16'hFFFF, 1'b0, 1'b1);
        op(16'h0001, 1'b0, 1'b0);
        drain();
        check("ripple_y", last_y, 16'h0000);
        check("ripple_co", last_co, 1);
`ifdef FABULOUS_ACC_STICKY_OVF_EN
        check("ovf_set", OVF, 1);
`endif

        op(16'h0005, 1'b0, 1'b1);
        op(16'h0007, 1'b1, 1'b0);
        drain();
        check("sub_y", last_y, 16'hFFFE);
        check("sub_co", last_co, 0);
        check("ovf_load_clr", OVF, 0);
        op(16'hFFF0, 1'b1, 1'b0);
        drain();
        check("sub2_y", last_y, 16'h000E);
        check("sub2_co", last_co, 1);

        base = n_out;
        op(16'h0100, 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) op(16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
            check("bp_iready", in_ready, 0);
        end
        op(16'h0010, 1'b0, 1'b0);
        drain();
        check("bp_count", n_out - base, 5);
        check("bp_last", last_y, 16'h0116);

        op(16'h0007, 1'b0, 1'b1);
        op(16'h0001, 1'b0, 1'b0);
        op(16'h0002, 1'b0, 1'b0);
        cycle(1'b1, 16'h0055, 1'b0, 1'b0, 1'b1, 1'b1);
        check("sr_ovalid", out_valid, 0);
        op(16'h0003, 1'b0, 1'b0);
        drain();
        check("sr_add", last_y, 16'h0003);

        for (int n = 0; n < 10000; n++) begin
            cycle($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 499) == 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
